neuron_integrator: RTL

Per-timestep integrate-and-fire core that consumes the axon spike vector from the spike-receive interface. On each `start` it snapshots the spike vector and applies leak to the membrane potential. It then scans the axons in order, fetching the synaptic weight of each active axon from an external synchronous weight memory, and accumulates with saturation. At the end of the scan it compares the potential to the threshold and emits a one-cycle `fire` pulse, which the downstream packetizer turns into an outgoing spike packet.

---
 rtl/neuron_integrator_pkg.sv | 17 +
 rtl/neuron_integrator_potential_sat_add.sv | 39 +++
 rtl/neuron_integrator.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/neuron_integrator_pkg.sv
// Shared definitions for the integrate-and-fire core: FSM encoding and
// width helpers for the saturating datapath.
package neuron_integrator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEAK    = 3'd1,
        ST_SCAN    = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_COMPARE = 3'd4
    } nstate_e;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neuron_integrator_potential_sat_add.sv
// Signed saturating adder: a P-bit potential plus a wider signed operand,
// clamped to the P-bit signed range instead of wrapping.
module potential_sat_add
    import neuron_integrator_pkg::*;
#(
    parameter int P_WIDTH = 24,
    parameter int B_WIDTH = 33
) (
    input  logic signed [P_WIDTH-1:0] i_a,
    input  logic signed [B_WIDTH-1:0] i_b,
    output logic signed [P_WIDTH-1:0] o_sum
);

    // One guard bit beyond the wider operand so the raw sum never overflows.
    localparam int S_WIDTH = max_width(P_WIDTH, B_WIDTH) + 1;

    localparam logic signed [S_WIDTH-1:0] MAX_VAL =
        {{(S_WIDTH-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [S_WIDTH-1:0] MIN_VAL =
        {{(S_WIDTH-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

    logic signed [S_WIDTH-1:0] w_a_ext;
    logic signed [S_WIDTH-1:0] w_b_ext;
    logic signed [S_WIDTH-1:0] w_sum_full;

    assign w_a_ext    = {{(S_WIDTH-P_WIDTH){i_a[P_WIDTH-1]}}, i_a};
    assign w_b_ext    = {{(S_WIDTH-B_WIDTH){i_b[B_WIDTH-1]}}, i_b};
    assign w_sum_full = w_a_ext + w_b_ext;

    always_comb begin
        o_sum = w_sum_full[P_WIDTH-1:0];
        if (w_sum_full > MAX_VAL) begin
            o_sum = MAX_VAL[P_WIDTH-1:0];
        end else if (w_sum_full < MIN_VAL) begin
            o_sum = MIN_VAL[P_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/neuron_integrator.sv
// Per-timestep integrate-and-fire core: leak, scan active axons fetching
// weights from a one-cycle-latency memory, accumulate with saturation, fire.
module neuron_integrator
    import neuron_integrator_pkg::*;
#(
    parameter int NUM_AXONS          = 2,
    parameter int AXON_CNT_BIT_WIDTH = 1,
    parameter int WEIGHT_WIDTH       = 16,
    parameter int POTENTIAL_WIDTH    = 24,
    parameter int THRESHOLD          = 100,
    parameter int LEAK               = 1
) (
    input  logic                              neuron_clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [(1<<AXON_CNT_BIT_WIDTH)-1:0] spike,
    output logic                              weight_rd_en,
    output logic [AXON_CNT_BIT_WIDTH-1:0]     weight_addr,
    input  logic [WEIGHT_WIDTH-1:0]           weight_data,
    output logic [POTENTIAL_WIDTH-1:0]        potential,
    output logic                              busy,
    output logic                              fire,
    output logic                              done,
    output logic                              step_overrun
);

    localparam int SPIKE_WIDTH = 1 << AXON_CNT_BIT_WIDTH;
    // Operand wide enough for either a weight or the full int range of +/-LEAK.
    localparam int OP_WIDTH    = max_width(WEIGHT_WIDTH, 32) + 1;

    localparam logic [AXON_CNT_BIT_WIDTH-1:0]       LAST_IDX = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);
    localparam logic signed [POTENTIAL_WIDTH-1:0]   THRESH   = POTENTIAL_WIDTH'(THRESHOLD);
    localparam logic signed [OP_WIDTH-1:0]          LEAK_POS = OP_WIDTH'(LEAK);
    localparam logic signed [OP_WIDTH-1:0]          LEAK_NEG = -LEAK_POS;

    nstate_e                              r_state;
    nstate_e                              w_state_next;
    logic [SPIKE_WIDTH-1:0]               r_spike_snap;
    logic [AXON_CNT_BIT_WIDTH-1:0]        r_idx;
    logic signed [POTENTIAL_WIDTH-1:0]    r_potential;
    logic                                 r_busy;
    logic                                 r_fire;
    logic                                 r_done;
    logic                                 r_overrun;

    logic [SPIKE_WIDTH-1:0]               w_spike_masked;
    logic                                 w_spike_cur;
    logic                                 w_last;
    logic                                 w_rd_en;
    logic signed [OP_WIDTH-1:0]           w_operand;
    logic signed [POTENTIAL_WIDTH-1:0]    w_sum;
    logic signed [POTENTIAL_WIDTH-1:0]    w_leak_result;

    genvar gi;
    generate
        for (gi = 0; gi < SPIKE_WIDTH; gi++) begin : g_spike_mask
            if (gi < NUM_AXONS) begin : g_live
                assign w_spike_masked[gi] = spike[gi];
            end else begin : g_dead
                assign w_spike_masked[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_spike_cur = r_spike_snap[r_idx];
    assign w_last      = (r_idx == LAST_IDX);

    // Leak pulls toward zero: subtract from positives, add to negatives.
    always_comb begin
        w_operand = r_potential[POTENTIAL_WIDTH-1] ? LEAK_POS : LEAK_NEG;
        if (r_state == ST_ACCUM) begin
            w_operand = {{(OP_WIDTH-WEIGHT_WIDTH){weight_data[WEIGHT_WIDTH-1]}}, weight_data};
        end
    end

    potential_sat_add #(
        .P_WIDTH (POTENTIAL_WIDTH),
        .B_WIDTH (OP_WIDTH)
    ) u_sat_add (
        .i_a   (r_potential),
        .i_b   (w_operand),
        .o_sum (w_sum)
    );

    // A sign flip means the leak would have crossed zero, so stop at zero.
    always_comb begin
        w_leak_result = w_sum;
        if ((r_potential == '0) || (r_potential[POTENTIAL_WIDTH-1] != w_sum[POTENTIAL_WIDTH-1])) begin
            w_leak_result = '0;
        end
    end

    always_ff @(posedge neuron_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LEAK;
                end
            end
            ST_LEAK: begin
                w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_spike_cur) begin
                    w_rd_en      = 1'b1;
                    w_state_next = ST_ACCUM;
                end else if (w_last) begin
                    w_state_next = ST_COMPARE;
                end
            end
            ST_ACCUM: begin
                w_state_next = w_last ? ST_COMPARE : ST_SCAN;
            end
            ST_COMPARE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge neuron_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_snap <= '0;
            r_idx        <= '0;
            r_potential  <= '0;
            r_busy       <= 1'b0;
            r_fire       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_fire    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= start && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_spike_snap <= w_spike_masked;
                        r_idx        <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_LEAK: begin
                    r_potential <= w_leak_result;
                end
                ST_SCAN: begin
                    if (!w_spike_cur && !w_last) begin
                        r_idx <= r_idx + AXON_CNT_BIT_WIDTH'(1);
                    end
                end
                ST_ACCUM: begin
                    r_potential <= w_sum;
                    if (!w_last) begin
                        r_idx <= r_idx + AXON_CNT_BIT_WIDTH'(1);
                    end
                end
                ST_COMPARE: begin
                    if (r_potential >= THRESH) begin
                        r_fire      <= 1'b1;
                        r_potential <= '0;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign weight_rd_en = w_rd_en;
    assign weight_addr  = r_idx;
    assign potential    = r_potential;
    assign busy         = r_busy;
    assign fire         = r_fire;
    assign done         = r_done;
    assign step_overrun = r_overrun;

endmodule
